// File: rtl/mult_pkg.sv
// Shared constants and helpers for the pipelined split-operand multiplier.
// Optional signed mode is enabled by defining PIPE_MULT_SIGNED_EN.
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        PP_LL = 2'd0,
        PP_LH = 2'd1,
        PP_HL = 2'd2,
        PP_HH = 2'd3
    } pp_sel_e;

    // Left shift applied to each partial product when recombining a width-bit product.
    function automatic int pp_shift(input pp_sel_e sel, input int width);
        int sh;
        case (sel)
            PP_HH:   sh = width;
            PP_HL:   sh = width / 2;
            PP_LH:   sh = width / 2;
            PP_LL:   sh = 0;
            default: sh = 0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/pipe_mult_if.sv
// Operand/result handshake bundle of pipe_mult; sgn exists only when
// PIPE_MULT_SIGNED_EN is defined.
interface pipe_mult_if #(
    parameter int WIDTH = mult_pkg::MULT_WIDTH_DEF
) ();

    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
`ifdef PIPE_MULT_SIGNED_EN
    logic               sgn;
`endif
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
`ifdef PIPE_MULT_SIGNED_EN
        output sgn,
`endif
        output x, y, in_valid, out_ready,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
`ifdef PIPE_MULT_SIGNED_EN
        input  sgn,
`endif
        input  x, y, in_valid, out_ready,
        output in_ready, out, out_valid, busy
    );

endinterface

// File: rtl/half_mult.sv
// Combinational HALF x HALF unsigned multiplier used for each partial product.
module half_mult #(
    parameter int HALF = 32
) (
    input  logic [HALF-1:0]   a,
    input  logic [HALF-1:0]   b,
    output logic [2*HALF-1:0] p
);

    assign p = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};

endmodule

// File: rtl/pipe_mult.sv
// Two-stage pipelined multiplier: stage A holds four partial products, stage B
// the recombined product. Define PIPE_MULT_SIGNED_EN to add the sgn input.
module pipe_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF,
    parameter int HALF  = WIDTH / 2
) (
    input  logic       clk,
    input  logic       rst,
    pipe_mult_if.slave bus
);

    logic [HALF-1:0]    xh_s, xl_s, yh_s, yl_s;
    logic [WIDTH-1:0]   hh_s, hl_s, lh_s, ll_s;
    logic [WIDTH-1:0]   hh_r, hl_r, lh_r, ll_r;
    logic               a_valid_r, b_valid_r;
    logic               a_adv_s, accept_s;
    logic [2*WIDTH-1:0] sum_s, out_r;
`ifdef PIPE_MULT_SIGNED_EN
    logic               a_sgn_r;
    logic [WIDTH-1:0]   a_x_r, a_y_r;
`endif

    assign xh_s = bus.x[WIDTH-1:HALF];
    assign xl_s = bus.x[HALF-1:0];
    assign yh_s = bus.y[WIDTH-1:HALF];
    assign yl_s = bus.y[HALF-1:0];

    half_mult #(.HALF(HALF)) u_hh (.a(xh_s), .b(yh_s), .p(hh_s));
    half_mult #(.HALF(HALF)) u_hl (.a(xh_s), .b(yl_s), .p(hl_s));
    half_mult #(.HALF(HALF)) u_lh (.a(xl_s), .b(yh_s), .p(lh_s));
    half_mult #(.HALF(HALF)) u_ll (.a(xl_s), .b(yl_s), .p(ll_s));

    // Stage A may move forward when B is empty or being drained this cycle.
    assign a_adv_s      = a_valid_r && (!b_valid_r || bus.out_ready);
    assign bus.in_ready = !a_valid_r || a_adv_s;
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign bus.busy     = a_valid_r || b_valid_r;
    assign bus.out      = out_r;
    assign bus.out_valid = b_valid_r;

    // Recombine partial products; signed mode subtracts the sign corrections mod 2^(2W).
    always_comb begin
        sum_s = ({{WIDTH{1'b0}}, hh_r} << pp_shift(PP_HH, WIDTH))
              + (({{WIDTH{1'b0}}, hl_r} << pp_shift(PP_HL, WIDTH))
              +  ({{WIDTH{1'b0}}, lh_r} << pp_shift(PP_LH, WIDTH)))
              + ({{WIDTH{1'b0}}, ll_r} << pp_shift(PP_LL, WIDTH));
`ifdef PIPE_MULT_SIGNED_EN
        sum_s = sum_s
              - ((a_sgn_r && a_x_r[WIDTH-1]) ? {a_y_r, {WIDTH{1'b0}}} : {(2*WIDTH){1'b0}})
              - ((a_sgn_r && a_y_r[WIDTH-1]) ? {a_x_r, {WIDTH{1'b0}}} : {(2*WIDTH){1'b0}});
`endif
    end

    // Stage A: capture partial products on acceptance, empty when advancing alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_r <= 1'b0;
            hh_r      <= {WIDTH{1'b0}};
            hl_r      <= {WIDTH{1'b0}};
            lh_r      <= {WIDTH{1'b0}};
            ll_r      <= {WIDTH{1'b0}};
`ifdef PIPE_MULT_SIGNED_EN
            a_sgn_r   <= 1'b0;
            a_x_r     <= {WIDTH{1'b0}};
            a_y_r     <= {WIDTH{1'b0}};
`endif
        end else if (accept_s) begin
            a_valid_r <= 1'b1;
            hh_r      <= hh_s;
            hl_r      <= hl_s;
            lh_r      <= lh_s;
            ll_r      <= ll_s;
`ifdef PIPE_MULT_SIGNED_EN
            a_sgn_r   <= bus.sgn;
            a_x_r     <= bus.x;
            a_y_r     <= bus.y;
`endif
        end else if (a_adv_s) begin
            a_valid_r <= 1'b0;
        end else begin
            a_valid_r <= a_valid_r;
        end
    end

    // Stage B: load the product from A, otherwise hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_r <= 1'b0;
            out_r     <= {(2*WIDTH){1'b0}};
        end else if (a_adv_s) begin
            b_valid_r <= 1'b1;
            out_r     <= sum_s;
        end else if (b_valid_r && bus.out_ready) begin
            b_valid_r <= 1'b0;
        end else begin
            b_valid_r <= b_valid_r;
        end
    end

endmodule

// File: tb/tb_pipe_mult.sv
// Self-checking bench for pipe_mult: directed table and corner sequences on a
// 64-bit instance, random scoreboard, and an exhaustive 8-bit sweep.
module tb_pipe_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_mult_if #(.WIDTH(64)) b64 ();
    pipe_mult_if #(.WIDTH(8))  b8 ();

    pipe_mult #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
    pipe_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0]  x;
        logic [63:0]  y;
        logic         sgn;
        logic [127:0] exp;
    } vec_t;

    vec_t         tbl[$];
    logic [127:0] exp_q[$];
    logic [15:0]  exp8_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: mathematical product, sign-extended operands when s is set.
    function automatic logic [127:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [127:0] sx, sy;
        if (s) begin
            sx = {{64{x[63]}}, x};
            sy = {{64{y[63]}}, y};
        end else begin
            sx = {64'd0, x};
            sy = {64'd0, y};
        end
        return sx * sy;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi, p;
        if (s) begin
            xi = int'($signed(x));
            yi = int'($signed(y));
        end else begin
            xi = int'(x);
            yi = int'(y);
        end
        p = xi * yi;
        return p[15:0];
    endfunction

    task automatic drive64(input logic [63:0] x, input logic [63:0] y, input logic v, input logic s);
        b64.x = x;
        b64.y = y;
        b64.in_valid = v;
`ifdef PIPE_MULT_SIGNED_EN
        b64.sgn = s;
`else
        if (s) $display("note: signed vector skipped in unsigned build");
`endif
    endtask

    initial begin
        logic [127:0] p0, p1, pc, prev;
        logic         stalled, s;
        logic [63:0]  rx, ry;
        int           sent, got, cyc, idx;

        rst = 1'b1;
        drive64(64'd0, 64'd0, 1'b0, 1'b0);
        b64.out_ready = 1'b1;
        b8.x = 8'd0; b8.y = 8'd0; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
`ifdef PIPE_MULT_SIGNED_EN
        b8.sgn = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {127'd0, b64.out_valid}, 128'd0);
        chk("rst_busy",      {127'd0, b64.busy}, 128'd0);
        chk("rst_in_ready",  {127'd0, b64.in_ready}, 128'd1);
        chk("rst_out",       b64.out, 128'd0);
        chk("rst8_in_ready", {127'd0, b8.in_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed table applied back to back with out_ready held high.
        tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
        tbl.push_back('{64'd2, 64'd3, 1'b0, 128'd6});
        tbl.push_back('{64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 128'h1_0000_0000_0000_0000});
        tbl.push_back('{64'd0, 64'd5, 1'b0, 128'd0});
        tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, 128'h6_FFFF_FFFF_FFFF_FFEB});
        tbl.push_back('{64'h8000_0000_0000_0000, 64'd2, 1'b0, 128'h1_0000_0000_0000_0000});
`ifdef PIPE_MULT_SIGNED_EN
        tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1,
                        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB});
        tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1});
`endif
        for (int c = 0; c < tbl.size() + 3; c++) begin
            @(negedge clk);
            if (c < tbl.size()) drive64(tbl[c].x, tbl[c].y, 1'b1, tbl[c].sgn);
            else drive64(64'd0, 64'd0, 1'b0, 1'b0);
            #1;
            if (c >= 2 && c < tbl.size() + 2) begin
                chk("tbl_out_valid", {127'd0, b64.out_valid}, 128'd1);
                chk("tbl_out", b64.out, tbl[c-2].exp);
            end else begin
                chk("tbl_no_valid", {127'd0, b64.out_valid}, 128'd0);
            end
        end

        // Backpressure: out_ready low for 4 cycles, in_valid held high.
        p0 = ref64(64'h1_0000_0003, 64'h5, 1'b0);
        p1 = ref64(64'hDEAD_BEEF_0000_0001, 64'h1234_5678, 1'b0);
        b64.out_ready = 1'b0;
        @(negedge clk); drive64(64'h1_0000_0003, 64'h5, 1'b1, 1'b0); #1;
        chk("bp_c0_in_ready", {127'd0, b64.in_ready}, 128'd1);
        @(negedge clk); drive64(64'hDEAD_BEEF_0000_0001, 64'h1234_5678, 1'b1, 1'b0); #1;
        chk("bp_c1_in_ready", {127'd0, b64.in_ready}, 128'd1);
        @(negedge clk); drive64(64'd9, 64'd9, 1'b1, 1'b0); #1;
        chk("bp_c2_in_ready", {127'd0, b64.in_ready}, 128'd0);
        chk("bp_c2_out", b64.out, p0);
        @(negedge clk); #1;
        chk("bp_c3_in_ready", {127'd0, b64.in_ready}, 128'd0);
        chk("bp_c3_out_hold", b64.out, p0);
        chk("bp_c3_valid", {127'd0, b64.out_valid}, 128'd1);
        @(negedge clk); drive64(64'd0, 64'd0, 1'b0, 1'b0); b64.out_ready = 1'b1; #1;
        chk("bp_drain0", b64.out, p0);
        @(negedge clk); #1;
        chk("bp_drain1", b64.out, p1);
        chk("bp_drain1_valid", {127'd0, b64.out_valid}, 128'd1);
        @(negedge clk); #1;
        chk("bp_empty_valid", {127'd0, b64.out_valid}, 128'd0);
        chk("bp_empty_busy", {127'd0, b64.busy}, 128'd0);

        // Reset pulse with both stages full.
        b64.out_ready = 1'b0;
        @(negedge clk); drive64(64'd11, 64'd13, 1'b1, 1'b0);
        @(negedge clk); drive64(64'd17, 64'd19, 1'b1, 1'b0);
        @(negedge clk); drive64(64'd0, 64'd0, 1'b0, 1'b0); #1;
        chk("rp_full_busy", {127'd0, b64.busy}, 128'd1);
        chk("rp_full_in_ready", {127'd0, b64.in_ready}, 128'd0);
        rst = 1'b1; #1;
        chk("rp_out_valid", {127'd0, b64.out_valid}, 128'd0);
        chk("rp_busy", {127'd0, b64.busy}, 128'd0);
        chk("rp_in_ready", {127'd0, b64.in_ready}, 128'd1);
        chk("rp_out", b64.out, 128'd0);
        @(negedge clk); rst = 1'b0; b64.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("rp_no_stale", {127'd0, b64.out_valid}, 128'd0);
        end
        pc = ref64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
        @(negedge clk); drive64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        @(negedge clk); drive64(64'd0, 64'd0, 1'b0, 1'b0); #1;
        chk("rp_resume_lat", {127'd0, b64.out_valid}, 128'd0);
        @(negedge clk); #1;
        chk("rp_resume_valid", {127'd0, b64.out_valid}, 128'd1);
        chk("rp_resume_out", b64.out, pc);

        // Random 64-bit traffic with random backpressure against the scoreboard.
        @(negedge clk);
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; prev = 128'd0;
        while (got < 300 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            rx = ($urandom_range(7, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            ry = ($urandom_range(7, 0) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
`ifdef PIPE_MULT_SIGNED_EN
            s = 1'($urandom_range(1, 0));
`else
            s = 1'b0;
`endif
            drive64(rx, ry, (sent < 300) && ($urandom_range(3, 0) != 0), s);
            b64.out_ready = 1'($urandom_range(1, 0));
            #1;
            if (stalled) begin
                chk("r64_hold_valid", {127'd0, b64.out_valid}, 128'd1);
                chk("r64_hold_out", b64.out, prev);
            end
            if (b64.out_valid && b64.out_ready) begin
                if (exp_q.size() == 0) chk("r64_unexpected", {127'd0, b64.out_valid}, 128'd0);
                else chk("r64_out", b64.out, exp_q.pop_front());
                got++;
            end
            if (b64.in_valid && b64.in_ready) begin
                exp_q.push_back(ref64(rx, ry, s));
                sent++;
            end
            stalled = b64.out_valid && !b64.out_ready;
            prev = b64.out;
        end
        chk("r64_done", 128'(got), 128'd300);
        drive64(64'd0, 64'd0, 1'b0, 1'b0);
        b64.out_ready = 1'b1;

        // Exhaustive 8-bit sweep with rare out_ready drops.
        idx = 0; got = 0; cyc = 0;
        while (got < 65536 && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            b8.x = idx[15:8];
            b8.y = idx[7:0];
            b8.in_valid = (idx < 65536);
`ifdef PIPE_MULT_SIGNED_EN
            b8.sgn = 1'($urandom_range(1, 0));
            s = b8.sgn;
`else
            s = 1'b0;
`endif
            b8.out_ready = ($urandom_range(31, 0) != 0);
            #1;
            if (b8.out_valid && b8.out_ready) begin
                if (exp8_q.size() == 0) chk("x8_unexpected", {127'd0, b8.out_valid}, 128'd0);
                else chk("x8_out", {112'd0, b8.out}, {112'd0, exp8_q.pop_front()});
                got++;
            end
            if (b8.in_valid && b8.in_ready) begin
                exp8_q.push_back(ref8(b8.x, b8.y, s));
                idx++;
            end
        end
        chk("x8_done", 128'(got), 128'd65536);
        b8.in_valid = 1'b0;
        @(negedge clk); #1;
        chk("x8_idle_busy", {127'd0, b8.busy}, 128'd0);
        chk("r64_idle_busy", {127'd0, b64.busy}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_mult.md
PIPE_MULT -- requirements
Module: pipe_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits; even, minimum 4.
REQ-002 SHALL have parameter HALF, default WIDTH/2, width of each partial-product operand half; derived, not overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port x  input  WIDTH  multiplicand.
REQ-006 SHALL have port y  input  WIDTH  multiplier.
REQ-007 SHALL have port in_valid  input  1  x/y present a transaction.
REQ-008 SHALL have port in_ready  output  1  block accepts a transaction this cycle.
REQ-009 SHALL have port out  output  2*WIDTH  product.
REQ-010 SHALL have port out_valid  output  1  out holds a valid product.
REQ-011 SHALL have port out_ready  input  1  consumer takes out this cycle.
REQ-012 SHALL have port busy  output  1  high while any pipeline stage holds a transaction.

Function
REQ-013 SHALL accept a transaction on a cycle where in_valid and in_ready are both high.
REQ-014 SHALL split each operand into high/low HALF-bit halves and form four HALF x HALF unsigned partial products: hh, hl, lh, ll.
REQ-015 SHALL register the four partial products and the valid flag in stage A on acceptance.
REQ-016 SHALL compute out = (hh << WIDTH) + ((hl + lh) << HALF) + ll, full 2*WIDTH width, no truncation, and register it in stage B.
REQ-017 SHALL present out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-018 SHALL sustain one accepted transaction per cycle while out_ready is high.
REQ-019 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL advance stage A into stage B only when stage B is empty or is being consumed in the same cycle.
REQ-021 SHALL drive in_ready = !A_valid || A_advance, combinationally, without depending on in_valid.
REQ-022 SHALL, when stage B is consumed and stage A is empty in the same cycle, clear out_valid on the next cycle.
REQ-023 SHALL accept a new transaction into stage A in the same cycle that stage A advances into stage B.
REQ-024 SHALL preserve transaction order, with no loss or duplication under any out_ready pattern.
REQ-025 SHALL drive busy = A_valid || B_valid.

Reset
REQ-026 SHALL, on rst high, asynchronously clear A_valid and B_valid, and set out to 0, busy to 0 and in_ready to 1.
REQ-027 SHALL discard any in-flight transactions on reset mid-operation; no partial result is emitted after reset deasserts.
REQ-028 SHALL resume accepting transactions on the first rising clk edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro PIPE_MULT_SIGNED_EN defined, add input port sgn (1 bit), captured with x/y on acceptance and carried through stage A.
REQ-030 SHALL, when sgn=1 in that mode, produce the two's-complement signed product by subtracting (y << WIDTH) if x[WIDTH-1]=1 and (x << WIDTH) if y[WIDTH-1]=1, modulo 2^(2*WIDTH), in stage B.
REQ-031 SHALL, without PIPE_MULT_SIGNED_EN, have no sgn port and compute unsigned products only, with latency unchanged in both modes.

Structure
REQ-032 SHALL place in a shared package mult_pkg the default WIDTH constant and a function for the partial-product recombination shift amounts.
REQ-033 SHALL instantiate one sub-module, half_mult (HALF x HALF unsigned, purely combinational), four times.
REQ-034 SHALL implement stage A and stage B registers inside pipe_mult, with no extra pipeline registers inside half_mult.

Verification
REQ-035 SHALL check, for WIDTH=64 and out_ready=1, x=0xFFFFFFFFFFFFFFFF, y=0xFFFFFFFFFFFFFFFF -> 2 cycles later out=0xFFFFFFFFFFFFFFFE0000000000000001, out_valid=1.
REQ-036 SHALL check back-to-back inputs (2,3), (0x100000000,0x100000000), (0,5) on consecutive cycles -> outputs 6, 0x1_0000_0000_0000_0000 and 0 on 3 consecutive cycles.
REQ-037 SHALL check backpressure: out_ready=0 for 4 cycles with in_valid held high -> in_ready falls after 2 accepts, out holds its first value stable, and all values drain in order once out_ready=1.
REQ-038 SHALL check rst pulse with both stages full -> out_valid=0, busy=0, in_ready=1 immediately, and no stale output afterwards.
REQ-039 SHALL check, with PIPE_MULT_SIGNED_EN defined and sgn=1, x=-3, y=7 -> out=-21 (0xFFFF...FFEB, 128 bits); with sgn=0 and the same bits -> unsigned product.
REQ-040 SHALL check WIDTH=8 exhaustively (65536 pairs, random out_ready) against a reference model.
